// File: rtl/sys_exec_unit.sv
// System execution unit: routes move-to/from SPR/CR results to the GPR, SPR or CR
// write-back bus through an in-order result queue that back-pressures issue.
package sys_exec_pkg;

  typedef enum logic [2:0] {
    SYS_NOP           = 3'd0,
    SYS_MOVE_TO_SPR   = 3'd1,
    SYS_MOVE_FROM_SPR = 3'd2,
    SYS_MOVE_TO_CR    = 3'd3,
    SYS_MOVE_FROM_CR  = 3'd4
  } system_op_t;

  typedef struct packed {
    system_op_t  op;
    logic [9:0]  spr_num;
    logic [7:0]  fxm;
  } system_decode_t;

endpackage

module sys_exec_unit
  import sys_exec_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic                           input_valid,
  output logic                           input_ready,
  input  logic [RS_ID_WIDTH-1:0]         rs_id_in,
  input  logic [4:0]                     result_reg_addr_in,
  input  logic [31:0]                    op1,
  input  system_decode_t                 control,

  output logic                           gpr_output_valid,
  input  logic                           gpr_output_ready,
  output logic [RS_ID_WIDTH-1:0]         gpr_rs_id_out,
  output logic [4:0]                     gpr_result_reg_addr_out,
  output logic [31:0]                    gpr_result,

  output logic                           spr_output_valid,
  input  logic                           spr_output_ready,
  output logic [RS_ID_WIDTH-1:0]         spr_rs_id_out,
  output logic [9:0]                     spr_result_reg_addr_out,
  output logic [31:0]                    spr_result,

  output logic                           cr_output_valid,
  input  logic                           cr_output_ready,
  output logic                           cr_enable [0:7],
  output logic [RS_ID_WIDTH-1:0]         cr_rs_id_out,
  output logic [31:0]                    cr_result,

  output logic [$clog2(FIFO_DEPTH+1)-1:0] queue_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] DEST_GPR = 2'd0;
  localparam logic [1:0] DEST_SPR = 2'd1;
  localparam logic [1:0] DEST_CR  = 2'd2;

  typedef struct packed {
    logic [1:0]             dest;
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             reg_addr;
    logic [9:0]             spr_num;
    logic [7:0]             fxm;
    logic [31:0]            value;
  } entry_t;

  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  entry_t             head;
  entry_t             new_entry;
  logic               legal_op;
  logic               not_empty;
  logic               push;
  logic               pop;

  // Destination decode; unknown operations are swallowed without enqueueing.
  always_comb begin
    legal_op       = 1'b1;
    new_entry      = '0;
    new_entry.dest = DEST_GPR;
    unique case (control.op)
      SYS_MOVE_TO_SPR:   new_entry.dest = DEST_SPR;
      SYS_MOVE_FROM_SPR: new_entry.dest = DEST_GPR;
      SYS_MOVE_FROM_CR:  new_entry.dest = DEST_GPR;
      SYS_MOVE_TO_CR:    new_entry.dest = DEST_CR;
      default:           legal_op       = 1'b0;
    endcase
    new_entry.rs_id    = rs_id_in;
    new_entry.reg_addr = result_reg_addr_in;
    new_entry.spr_num  = control.spr_num;
    new_entry.fxm      = control.fxm;
    new_entry.value    = op1;
  end

  // Ready depends only on the stored count, never on the output readies.
  assign input_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign queue_count = count_q;
  assign not_empty   = (count_q != '0);
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    gpr_output_valid        = not_empty && (head.dest == DEST_GPR);
    spr_output_valid        = not_empty && (head.dest == DEST_SPR);
    cr_output_valid         = not_empty && (head.dest == DEST_CR);

    gpr_rs_id_out           = head.rs_id;
    spr_rs_id_out           = head.rs_id;
    cr_rs_id_out            = head.rs_id;
    gpr_result              = head.value;
    spr_result              = head.value;
    cr_result               = head.value;
    gpr_result_reg_addr_out = head.reg_addr;
    spr_result_reg_addr_out = head.spr_num;
    for (int i = 0; i < 8; i++) begin
      cr_enable[i] = head.fxm[i];
    end
  end

  assign pop  = (gpr_output_valid && gpr_output_ready) ||
                (spr_output_valid && spr_output_ready) ||
                (cr_output_valid  && cr_output_ready);
  assign push = input_valid && input_ready && legal_op;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_sys_exec_unit.sv
// Self-checking bench for sys_exec_unit: a scoreboard queue is filled at issue
// and drained by a negedge monitor that checks every bus handshake in order.
module tb_sys_exec_unit;
  import sys_exec_pkg::*;

  localparam int RSW   = 5;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                input_valid;
  logic                input_ready;
  logic [RSW-1:0]      rs_id_in;
  logic [4:0]          result_reg_addr_in;
  logic [31:0]         op1;
  system_decode_t      control;
  logic                gpr_output_valid, gpr_output_ready;
  logic [RSW-1:0]      gpr_rs_id_out;
  logic [4:0]          gpr_result_reg_addr_out;
  logic [31:0]         gpr_result;
  logic                spr_output_valid, spr_output_ready;
  logic [RSW-1:0]      spr_rs_id_out;
  logic [9:0]          spr_result_reg_addr_out;
  logic [31:0]         spr_result;
  logic                cr_output_valid, cr_output_ready;
  logic                cr_enable [0:7];
  logic [RSW-1:0]      cr_rs_id_out;
  logic [31:0]         cr_result;
  logic [2:0]          queue_count;
  logic [7:0]          cr_en_v;

  sys_exec_unit #(.RS_ID_WIDTH(RSW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_ready(input_ready),
    .rs_id_in(rs_id_in), .result_reg_addr_in(result_reg_addr_in),
    .op1(op1), .control(control),
    .gpr_output_valid(gpr_output_valid), .gpr_output_ready(gpr_output_ready),
    .gpr_rs_id_out(gpr_rs_id_out), .gpr_result_reg_addr_out(gpr_result_reg_addr_out),
    .gpr_result(gpr_result),
    .spr_output_valid(spr_output_valid), .spr_output_ready(spr_output_ready),
    .spr_rs_id_out(spr_rs_id_out), .spr_result_reg_addr_out(spr_result_reg_addr_out),
    .spr_result(spr_result),
    .cr_output_valid(cr_output_valid), .cr_output_ready(cr_output_ready),
    .cr_enable(cr_enable), .cr_rs_id_out(cr_rs_id_out), .cr_result(cr_result),
    .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    cr_en_v = '0;
    for (int i = 0; i < 8; i++) cr_en_v[i] = cr_enable[i];
  end

  typedef struct {
    logic [1:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  addr;
    logic [9:0]  spr;
    logic [7:0]  fxm;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // 0 = GPR, 1 = SPR, 2 = CR, 3 = discarded
  function automatic logic [1:0] dest_of(input system_op_t op);
    case (op)
      SYS_MOVE_TO_SPR:                    return 2'd1;
      SYS_MOVE_FROM_SPR, SYS_MOVE_FROM_CR: return 2'd0;
      SYS_MOVE_TO_CR:                     return 2'd2;
      default:                            return 2'd3;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] b;
    if (!rst) begin
      n_checks++;
      if (queue_count > 3'(DEPTH)) begin
        n_fail++;
        $display("FAIL count_bound: queue_count=%0d max=%0d", queue_count, DEPTH);
      end
      n_checks++;
      if (int'(gpr_output_valid) + int'(spr_output_valid) + int'(cr_output_valid) > 1) begin
        n_fail++;
        $display("FAIL onehot_valid: gpr=%b spr=%b cr=%b, at most one expected",
                 gpr_output_valid, spr_output_valid, cr_output_valid);
      end
      b = 2'd3;
      if (gpr_output_valid && gpr_output_ready)      b = 2'd0;
      else if (spr_output_valid && spr_output_ready) b = 2'd1;
      else if (cr_output_valid && cr_output_ready)   b = 2'd2;
      if (b != 2'd3) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: bus=%0d fired with empty scoreboard", b);
        end else begin
          e = sb.pop_front();
          if (b != e.dest) begin
            n_fail++;
            $display("FAIL route: bus=%0d expected bus=%0d (val %h)", b, e.dest, e.val);
          end else if (b == 2'd0 && (gpr_rs_id_out !== e.rs || gpr_result_reg_addr_out !== e.addr ||
                                     gpr_result !== e.val)) begin
            n_fail++;
            $display("FAIL gpr_fields: got rs=%0d addr=%0d val=%h expected rs=%0d addr=%0d val=%h",
                     gpr_rs_id_out, gpr_result_reg_addr_out, gpr_result, e.rs, e.addr, e.val);
          end else if (b == 2'd1 && (spr_rs_id_out !== e.rs || spr_result_reg_addr_out !== e.spr ||
                                     spr_result !== e.val)) begin
            n_fail++;
            $display("FAIL spr_fields: got rs=%0d spr=%h val=%h expected rs=%0d spr=%h val=%h",
                     spr_rs_id_out, spr_result_reg_addr_out, spr_result, e.rs, e.spr, e.val);
          end else if (b == 2'd2 && (cr_rs_id_out !== e.rs || cr_en_v !== e.fxm ||
                                     cr_result !== e.val)) begin
            n_fail++;
            $display("FAIL cr_fields: got rs=%0d en=%h val=%h expected rs=%0d en=%h val=%h",
                     cr_rs_id_out, cr_en_v, cr_result, e.rs, e.fxm, e.val);
          end
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input system_op_t op, input logic [4:0] rs, input logic [4:0] addr,
                       input logic [31:0] val, input logic [9:0] spr, input logic [7:0] fxm);
    exp_t e;
    int   budget = 0;
    input_valid        = 1'b1;
    control.op         = op;
    control.spr_num    = spr;
    control.fxm        = fxm;
    rs_id_in           = rs;
    result_reg_addr_in = addr;
    op1                = val;
    @(negedge clk);
    while (!input_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (!input_ready) begin
      n_fail++;
      $display("FAIL issue_timeout: input_ready=%b after %0d cycles, expected 1", input_ready, budget);
    end else if (dest_of(op) != 2'd3) begin
      e.dest = dest_of(op); e.rs = rs; e.addr = addr; e.spr = spr; e.fxm = fxm; e.val = val;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    input_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic g, input logic s, input logic c);
    gpr_output_ready = g;
    spr_output_ready = s;
    cr_output_ready  = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (queue_count !== 3'd0 || input_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: count=%0d ready=%b expected 0 and 1", queue_count, input_ready);
    end
    n_checks++;
    if ({gpr_output_valid, spr_output_valid, cr_output_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_valid: valids=%b expected 000",
               {gpr_output_valid, spr_output_valid, cr_output_valid});
    end
    n_checks++;
    if (gpr_result !== 32'h0 || spr_result !== 32'h0 || cr_result !== 32'h0 || cr_en_v !== 8'h0 ||
        gpr_result_reg_addr_out !== 5'h0 || spr_result_reg_addr_out !== 10'h0 || gpr_rs_id_out !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_data: gpr=%h spr=%h cr=%h en=%h expected all 0",
               gpr_result, spr_result, cr_result, cr_en_v);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_ready(1'b1, 1'b1, 1'b1);
    issue(SYS_MOVE_TO_SPR, 5'd3, 5'd0, 32'hDEADBEEF, 10'h120, 8'h00);
    @(negedge clk);
    n_checks++;
    if (spr_output_valid !== 1'b1 || spr_result !== 32'hDEADBEEF ||
        spr_result_reg_addr_out !== 10'h120 || spr_rs_id_out !== 5'd3) begin
      n_fail++;
      $display("FAIL single_latency: valid=%b val=%h spr=%h rs=%0d expected 1 deadbeef 120 3",
               spr_output_valid, spr_result, spr_result_reg_addr_out, spr_rs_id_out);
    end
    n_checks++;
    if (gpr_output_valid !== 1'b0 || cr_output_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_other_bus: gpr=%b cr=%b expected 0 0", gpr_output_valid, cr_output_valid);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_fill_stall();
    exp_t e;
    logic acc = 1'b0;
    set_ready(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++)
      issue(SYS_MOVE_FROM_CR, 5'(i), 5'(i + 8), 32'(i), 10'h0, 8'h0);
    input_valid = 1'b1; control.op = SYS_MOVE_FROM_CR; rs_id_in = 5'd5;
    result_reg_addr_in = 5'd13; op1 = 32'd5;
    @(negedge clk);
    n_checks++;
    if (input_ready !== 1'b0 || queue_count !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_full: ready=%b count=%0d expected 0 4", input_ready, queue_count);
    end
    @(posedge clk);
    #1;
    gpr_output_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (gpr_output_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_consecutive: cycle %0d gpr_valid=%b expected 1", k, gpr_output_valid);
      end
      if (!acc && input_ready) begin
        e.dest = 2'd0; e.rs = 5'd5; e.addr = 5'd13; e.spr = 10'h0; e.fxm = 8'h0; e.val = 32'd5;
        sb.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) input_valid = 1'b0;
    end
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL fifth_accept: accepted=%b expected 1", acc);
    end
    input_valid = 1'b0;
    drain();
  endtask

  task automatic test_hol();
    set_ready(1'b1, 1'b1, 1'b0);
    issue(SYS_MOVE_TO_CR, 5'd7, 5'd0, 32'hAAAA0000, 10'h0, 8'h81);
    issue(SYS_MOVE_FROM_SPR, 5'd8, 5'd4, 32'd7, 10'h3F, 8'h0);
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (gpr_output_valid !== 1'b0 || cr_output_valid !== 1'b1 || cr_en_v !== 8'h81) begin
        n_fail++;
        $display("FAIL hol_stall: gpr=%b cr=%b en=%h expected 0 1 81",
                 gpr_output_valid, cr_output_valid, cr_en_v);
      end
      @(posedge clk);
      #1;
    end
    cr_output_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (gpr_output_valid !== 1'b1 || gpr_result !== 32'd7) begin
      n_fail++;
      $display("FAIL hol_release: gpr_valid=%b val=%h expected 1 7", gpr_output_valid, gpr_result);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_stream();
    logic done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          issue(system_op_t'(3'($urandom_range(1, 4))), 5'(i), 5'($urandom),
                $urandom, 10'($urandom), 8'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          set_ready(1'($urandom), 1'($urandom), 1'($urandom));
        end
      end
    join
    set_ready(1'b1, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_illegal();
    logic [2:0] c;
    set_ready(1'b1, 1'b1, 1'b1);
    c = queue_count;
    issue(system_op_t'(3'd7), 5'd9, 5'd9, 32'h1234, 10'h1, 8'hFF);
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (queue_count !== c || input_ready !== 1'b1 ||
          {gpr_output_valid, spr_output_valid, cr_output_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL illegal_op: count=%0d ready=%b valids=%b expected %0d 1 000", queue_count,
                 input_ready, {gpr_output_valid, spr_output_valid, cr_output_valid}, c);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    set_ready(1'b0, 1'b0, 1'b0);
    issue(SYS_MOVE_TO_SPR, 5'd1, 5'd0, 32'h11, 10'h5, 8'h0);
    issue(SYS_MOVE_FROM_CR, 5'd2, 5'd2, 32'h22, 10'h0, 8'h0);
    issue(SYS_MOVE_TO_CR, 5'd3, 5'd0, 32'h33, 10'h0, 8'h0F);
    @(negedge clk);
    n_checks++;
    if (queue_count !== 3'd3) begin
      n_fail++;
      $display("FAIL pre_reset_count: count=%0d expected 3", queue_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (queue_count !== 3'd0 || input_ready !== 1'b1 ||
        {gpr_output_valid, spr_output_valid, cr_output_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid: count=%0d ready=%b valids=%b expected 0 1 000", queue_count,
               input_ready, {gpr_output_valid, spr_output_valid, cr_output_valid});
    end
    @(posedge clk);
    #1;
    set_ready(1'b1, 1'b1, 1'b1);
    issue(SYS_MOVE_FROM_SPR, 5'd4, 5'd17, 32'hCAFE0001, 10'h0, 8'h0);
    @(negedge clk);
    n_checks++;
    if (gpr_output_valid !== 1'b1 || gpr_result !== 32'hCAFE0001 || gpr_result_reg_addr_out !== 5'd17) begin
      n_fail++;
      $display("FAIL post_reset_latency: valid=%b val=%h addr=%0d expected 1 cafe0001 17",
               gpr_output_valid, gpr_result, gpr_result_reg_addr_out);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst = 1'b1;
    input_valid = 1'b0;
    rs_id_in = '0;
    result_reg_addr_in = '0;
    op1 = '0;
    control = '0;
    set_ready(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fill_stall();
    test_hol();
    test_stream();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sys_exec_unit.md
# sys_exec_unit

Parametrised successor of the system execution unit. It executes move-to/from SPR and move-to/from CR operations from the system reservation station. Each result is routed to the GPR, SPR or CR write-back bus, and every bus honours its ready signal. Results wait in an in-order result queue of configurable depth, so a stalled write-back bus back-pressures issue through `input_ready` and no result is ever dropped.

## Interface
- `RS_ID_WIDTH`, 5, width of the reservation-station tag.
- `FIFO_DEPTH`, 4, result-queue entries; power of two, ≥ 2.
- `clk` in 1, clock.
- `rst` in 1, reset; synchronous, active-high.
- `input_valid` in 1, issue request.
- `input_ready` out 1, high when the queue can accept an operation.
- `rs_id_in` in RS_ID_WIDTH, issuing tag.
- `result_reg_addr_in` in 5, destination GPR.
- `op1` in 32, source operand (GPR, SPR or CR value, already read).
- `control` in system_decode_t, operation, SPR number (10 b), FXM (8 b).
- `gpr_output_valid` out 1; `gpr_output_ready` in 1; `gpr_rs_id_out` out RS_ID_WIDTH; `gpr_result_reg_addr_out` out 5; `gpr_result` out 32.
- `spr_output_valid` out 1; `spr_output_ready` in 1; `spr_rs_id_out` out RS_ID_WIDTH; `spr_result_reg_addr_out` out 10; `spr_result` out 32.
- `cr_output_valid` out 1; `cr_output_ready` in 1; `cr_enable[0:7]` out 8×1 (unpacked); `cr_rs_id_out` out RS_ID_WIDTH; `cr_result` out 32.
- `queue_count` out $clog2(FIFO_DEPTH+1), current occupancy (debug/perf).

## Operation
- **Accept:** an operation is accepted on a rising edge with `input_valid && input_ready`.
- **Destination decode** at accept:
  - SYS_MOVE_TO_SPR → SPR bus.
  - SYS_MOVE_FROM_SPR and SYS_MOVE_FROM_CR → GPR bus.
  - SYS_MOVE_TO_CR → CR bus.
  - Any other operation is accepted and discarded. It is not enqueued and produces no output.
- **Queue entry:** destination (2 b), rs_id, result_reg_addr, SPR number, FXM, and `op1` as the result value.
- **Queue type:** circular buffer with `FIFO_DEPTH` entries. Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo `FIFO_DEPTH`.
- **Head presentation:** when the queue is non-empty, the head entry is shown on the bus matching its destination only; the other two valids are 0.
  - All three rs_id outputs carry the head rs_id.
  - All three result fields carry the head value.
  - `spr_result_reg_addr_out` = head SPR number.
  - `gpr_result_reg_addr_out` = head GPR address.
  - `cr_enable[i]` = head FXM[i].
- **Pop:** the head pops on an edge where its bus valid and that bus's ready are both high. Ready on the other buses is ignored.
- **Ordering:** results leave strictly in issue order. A stalled head blocks later entries even if they target other buses.
- **Backpressure:** `input_ready` = (`queue_count` != `FIFO_DEPTH`). It is registered-state only and has no combinational path from any output ready.
- **Simultaneous push and pop:** when not full, both occur in the same cycle and the count is unchanged.
- **Full:** when full, no push happens even if the head pops that cycle; `input_ready` rises the following cycle.
- **Empty:** all output valids are 0, and data outputs hold the last head-slot contents.

## Timing
- **Latency:** accept at edge N → result valid during cycle N+1 (after edge N) when the queue was empty. Otherwise it appears behind older entries.
- **Output stability:** outputs are held stable while valid && !ready, with no change until the pop.
- **Throughput:** one accept and one pop per cycle, sustained.
- **Reset:** storage and all control state are cleared.
  - `queue_count` = 0, pointers = 0, `input_ready` = 1.
  - All valids = 0, and all data outputs, `cr_enable` and address outputs = 0.
- **Reset mid-operation:** queued entries are discarded without output. Valids are 0 in the cycle after `rst` is sampled high.

## Test plan
- **Single op, latency and routing:** issue MOVE_TO_SPR, op1=0xDEADBEEF, SPR=0x120, rs_id=3, `spr_output_ready`=1 → `spr_output_valid` high exactly one cycle later with `spr_result`=0xDEADBEEF, `spr_result_reg_addr_out`=0x120, `spr_rs_id_out`=3; gpr/cr valids stay 0.
- **Fill and stall:** hold `gpr_output_ready`=0 and issue 5 MOVE_FROM_CR ops (op1=1..5), DEPTH=4 → 4 accepted, `input_ready`=0 and `queue_count`=4. Release ready → results 1,2,3,4 in order on consecutive cycles, then the 5th op is accepted.
- **Head-of-line ordering:** queue MOVE_TO_CR (FXM=0x81, op1=0xAAAA0000) then MOVE_FROM_SPR (op1=7), `cr_output_ready`=0, `gpr_output_ready`=1 → GPR valid stays 0 until the CR pop. `cr_enable` = {1,0,0,0,0,0,0,1} throughout the stall.
- **Wrap-around under streaming:** 20 back-to-back ops of mixed destination with random ready toggling → every op emerges exactly once, in order, with correct bus and fields; `queue_count` never exceeds 4.
- **Illegal operation:** issue an undefined operation code → accepted (`input_ready` unaffected); no valid on any bus; `queue_count` unchanged.
- **Reset mid-stream:** 3 entries queued with readies low, assert `rst` one cycle → next cycle all valids 0, `queue_count`=0, `input_ready`=1. The first post-reset op emerges with latency 1.
